alu_result_framer: RTL
======================

Name: alu_result_framer

Overview:
Sequencer that takes a 16-bit ALU result over a valid/ready handshake and sends it as a 4-byte frame through the shared byte-wide UART transmitter, using the transmitter's start/busy interface. The frame is SYNC, result[15:8], result[7:0], CHECKSUM. It replaces the single-byte INIT/SEND/WAIT control path, so the full 16-bit result reaches the host. It sits between the ALU output and the UART_TX instance.

Parameters:
SYNC_BYTE, 8'hA5, first byte of every frame
BUSY_TIMEOUT, 16, max cycles from uart_start until uart_busy must rise; range 2..255

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low aborts any frame in flight
req_valid  input  1  requester has a result
req_result  input  16  ALU result, sampled on accept
req_ready  output  1  block can accept; high = ena && state==IDLE && !uart_busy
uart_start  output  1  one-cycle start strobe to UART_TX
uart_data  output  8  byte to transmit; held stable from START through WAIT_IDLE
uart_busy  input  1  UART_TX busy flag
frame_done  output  1  one-cycle pulse when all 4 bytes have completed
frame_err  output  1  sticky: busy-rise timeout occurred; cleared on next accept

Behaviour:
- Reset (reset_n=0, async): state=IDLE, idx=0, timer=0, uart_data=8'h00, uart_start=0, frame_done=0, frame_err=0.
- Outputs uart_start, req_ready and frame_done decode from registered state plus uart_busy/ena only. No path from req_* to outputs.
- Accept: on the edge where req_valid && req_ready:
  - latch hi=req_result[15:8], lo=req_result[7:0], chk=SYNC_BYTE^hi^lo (8-bit XOR);
  - idx=0, uart_data=SYNC_BYTE, frame_err=0, state becomes START.
- States:
  - IDLE: wait for accept.
  - START: uart_start=1 for exactly this one cycle. Next state WAIT_BUSY, timer=0.
  - WAIT_BUSY: if uart_busy, go to WAIT_IDLE. Else timer++. When timer reaches BUSY_TIMEOUT-1 without busy: frame_err=1, go to IDLE, idx=0, no frame_done.
  - WAIT_IDLE: if !uart_busy and idx==3, go to DONE. If !uart_busy and idx<3: idx++, uart_data=byte[idx+1], go to START. No timeout in this state.
  - DONE: frame_done=1 for one cycle, then IDLE.
  - Unreachable encodings: go to IDLE.
- Byte order: byte[0]=SYNC_BYTE, byte[1]=hi, byte[2]=lo, byte[3]=chk.
- Latency: accept at edge k gives uart_start high in cycle k+1. With a UART that asserts busy one cycle after start, per-byte overhead is 3 cycles plus the UART busy time.
- ena low, any state, sampled at an edge:
  - next state IDLE, idx=0, uart_start deasserts next cycle;
  - no frame_done; frame_err held.
  - A UART byte already started is allowed to finish. The next accept waits via req_ready on !uart_busy.
- uart_busy high while in IDLE: req_ready=0, so nothing is accepted.
- req_valid high during a frame: ignored, req_ready=0, and the requester holds its data.
- uart_busy already high in the START cycle: WAIT_BUSY sees busy on its first cycle and proceeds normally.
- Back-to-back frames: DONE→IDLE, then accept is possible in the IDLE cycle. There is a minimum of 1 idle cycle between frames.

Decomposition:
- Shared package holds:
  - state encoding localparams IDLE, START, WAIT_BUSY, WAIT_IDLE, DONE (3 bits);
  - FRAME_LEN=4, the byte-index width, and the default SYNC_BYTE.
- One sub-module, tx_busy_watchdog:
  - inputs clear/count, output expired at BUSY_TIMEOUT-1;
  - parameterised by BUSY_TIMEOUT;
  - keep_hierarchy.

Test Plan:
- Result 16'h1234, UART model busy 1 cycle after start for 10 cycles: uart_data sequence A5,12,34,83; four uart_start pulses, each 1 cycle; frame_done once after the 4th busy falls; frame_err=0.
- Result 16'hFFFF with SYNC_BYTE=8'h00: bytes 00,FF,FF,00; checksum 00.
- UART model never raises busy, BUSY_TIMEOUT=16: one uart_start, frame_err=1 at cycle 16 after start, state IDLE, no frame_done. Next accept clears frame_err.
- ena dropped during byte 2's WAIT_IDLE: uart_start stays 0 afterward, no frame_done, req_ready stays 0 until busy falls, then 1 with ena high. New request 16'h00A5 sends A5,00,A5,00.
- req_valid held high continuously with result toggling each cycle: exactly one accept per frame, and data matches the value at each accept edge.
- reset_n asserted mid-byte (asynchronous, between edges): uart_start=0, frame_done=0, frame_err=0 immediately. After release, req_ready=1 once uart_busy=0.

Source files
------------

// File: rtl/alu_result_framer_pkg.sv
// Shared state encoding, frame geometry and checksum helper for the ALU result framer.
package alu_result_framer_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_IDLE = 3'd3,
    DONE      = 3'd4
  } state_e;

  localparam int         FRAME_LEN     = 4;
  localparam int         IDX_W         = 2;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  function automatic logic [7:0] frame_chk(input logic [7:0] sync_b,
                                           input logic [7:0] hi_b,
                                           input logic [7:0] lo_b);
    return sync_b ^ hi_b ^ lo_b;
  endfunction

endpackage

// File: rtl/alu_result_framer_tx_busy_watchdog.sv
// Counts cycles spent waiting for the UART busy flag to rise.
// Latency: expired is combinational on the cycle whose increment reaches BUSY_TIMEOUT-1.
// Backpressure: none; clear has priority over count.
module tx_busy_watchdog #(
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic clock_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic count_i,
  output logic expired_o
);

  localparam logic [7:0] LIMIT = 8'(BUSY_TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (count_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  assign expired_o = count_i && !clear_i && (cnt_d == LIMIT);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_result_framer.sv
// Frames a 16-bit ALU result as SYNC, hi, lo, checksum through a start/busy byte UART.
// Latency: accept at edge k gives uart_start in cycle k+1; 3 cycles overhead per byte plus UART busy time.
// Backpressure: req_ready only in IDLE with ena high and UART idle; requester holds data otherwise.
module alu_result_framer
  import alu_result_framer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
  parameter int         BUSY_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ena,
  input  logic        req_valid,
  input  logic [15:0] req_result,
  output logic        req_ready,
  output logic        uart_start,
  output logic [7:0]  uart_data,
  input  logic        uart_busy,
  output logic        frame_done,
  output logic        frame_err
);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       hi_q;
  logic [7:0]       lo_q;
  logic [7:0]       chk_q;
  logic [7:0]       data_q;
  logic             err_q;

  logic wd_clear;
  logic wd_count;
  logic wd_expired;
  logic accept;

  // Outputs decode only from registered state, busy and ena; req_* never reaches them.
  assign req_ready  = ena && (state_q == IDLE) && !uart_busy;
  assign uart_start = (state_q == START);
  assign frame_done = (state_q == DONE);
  assign uart_data  = data_q;
  assign frame_err  = err_q;
  assign accept     = req_valid && req_ready;

  assign wd_clear = (state_q != WAIT_BUSY);
  assign wd_count = (state_q == WAIT_BUSY) && !uart_busy;

  (* keep_hierarchy = "yes" *)
  tx_busy_watchdog #(
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) u_busy_wd (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .clear_i   (wd_clear),
    .count_i   (wd_count),
    .expired_o (wd_expired)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hi_q    <= 8'h00;
      lo_q    <= 8'h00;
      chk_q   <= 8'h00;
      data_q  <= 8'h00;
      err_q   <= 1'b0;
    end else if (!ena) begin
      // Abort: a byte already handed to the UART finishes on its own.
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            hi_q    <= req_result[15:8];
            lo_q    <= req_result[7:0];
            chk_q   <= frame_chk(SYNC_BYTE, req_result[15:8], req_result[7:0]);
            idx_q   <= '0;
            data_q  <= SYNC_BYTE;
            err_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (uart_busy) begin
            state_q <= WAIT_IDLE;
          end else if (wd_expired) begin
            err_q   <= 1'b1;
            idx_q   <= '0;
            state_q <= IDLE;
          end
        end
        WAIT_IDLE: begin
          if (!uart_busy) begin
            if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
              case (idx_q)
                2'd0:    data_q <= hi_q;
                2'd1:    data_q <= lo_q;
                default: data_q <= chk_q;
              endcase
              state_q <= START;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule
